// File: rtl/piplup_sprite_fetch_pkg.sv
// Shared types and helpers for the Piplup sprite fetch path.
package piplup_pkg;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } anim_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One extra bit keeps base+size from wrapping near the screen edge.
    function automatic logic in_span(input logic [9:0] coord, input logic [9:0] base,
                                     input int size);
        logic [10:0] c;
        logic [10:0] b;
        c = {1'b0, coord};
        b = {1'b0, base};
        return (c >= b) && (c < b + 11'(size));
    endfunction

endpackage

// File: rtl/piplup_sprite_fetch_if.sv
// Video, game-state and sprite-ROM signals of the sprite fetch stage.
interface piplup_sprite_fetch_if #(
    parameter int ADDR_W = 14
);
    import piplup_pkg::*;

    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              active;
    logic              frame_start;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    dir_t              dir;
    logic              moving;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [7:0]        pal_index;
    logic              pix_valid;
    logic              active_d;

    modport master (
        output DrawX, DrawY, active, frame_start, pos_x, pos_y, dir, moving, rom_data,
        input  rom_addr, pal_index, pix_valid, active_d
    );

    modport slave (
        input  DrawX, DrawY, active, frame_start, pos_x, pos_y, dir, moving, rom_data,
        output rom_addr, pal_index, pix_valid, active_d
    );

endinterface

// File: rtl/piplup_sprite_fetch_anim_fsm.sv
// Walk-animation state machine; advances only on frame_start pulses.
module piplup_anim_fsm
    import piplup_pkg::*;
#(
    parameter int FRAMES      = 4,
    parameter int FRAME_TICKS = 8
) (
    input  logic                            Clk,
    input  logic                            Reset_n,
    input  logic                            i_frame_start,
    input  logic                            i_moving,
    output logic [clog2_min1(FRAMES)-1:0]   o_anim_frame
);

    localparam int TW = clog2_min1(FRAME_TICKS);
    localparam int FW = clog2_min1(FRAMES);

    anim_state_t   r_state;
    anim_state_t   w_state_nxt;
    logic [TW-1:0] r_tick;
    logic [TW-1:0] w_tick_nxt;
    logic [FW-1:0] r_frame;
    logic [FW-1:0] w_frame_nxt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_frame <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_frame <= w_frame_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_frame_start) begin
            case (r_state)
                IDLE:    if (i_moving)  w_state_nxt = WALK;
                WALK:    if (!i_moving) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Counters stay cleared outside WALK; FRAMES is a power of two so the increment wraps itself.
    always_comb begin
        w_tick_nxt  = r_tick;
        w_frame_nxt = r_frame;
        if (i_frame_start) begin
            if (r_state == WALK && i_moving) begin
                if (r_tick == TW'(FRAME_TICKS - 1)) begin
                    w_tick_nxt  = '0;
                    w_frame_nxt = r_frame + 1'b1;
                end else begin
                    w_tick_nxt = r_tick + 1'b1;
                end
            end else begin
                w_tick_nxt  = '0;
                w_frame_nxt = '0;
            end
        end
    end

    assign o_anim_frame = r_frame;

endmodule

// File: rtl/piplup_sprite_fetch.sv
// Sprite hit test and ROM address generation, 3-clock pipeline into the palette stage.
module piplup_sprite_fetch
    import piplup_pkg::*;
#(
    parameter int         SPR_W           = 32,
    parameter int         SPR_H           = 32,
    parameter int         FRAMES          = 4,
    parameter int         FRAME_TICKS     = 8,
    parameter logic [7:0] TRANSPARENT_IDX = 8'h00,
    parameter int         ADDR_W          = 14
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    piplup_sprite_fetch_if.slave bus
);

    localparam int XW = clog2_min1(SPR_W);
    localparam int YW = clog2_min1(SPR_H);
    localparam int FW = clog2_min1(FRAMES);

    logic [9:0]        r_lpos_x;
    logic [9:0]        r_lpos_y;
    dir_t              r_ldir;
    logic [FW-1:0]     w_anim_frame;
    logic              w_hit;
    logic [XW-1:0]     w_xo;
    logic [YW-1:0]     w_yo;
    logic [ADDR_W-1:0] w_addr;
    logic              w_opaque;
    logic              r_hit_s1;
    logic              r_hit_s2;
    logic              r_active_s1;
    logic              r_active_s2;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [7:0]        r_pal_index;
    logic              r_pix_valid;
    logic              r_active_d;

    piplup_anim_fsm #(
        .FRAMES      (FRAMES),
        .FRAME_TICKS (FRAME_TICKS)
    ) u_anim_fsm (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .i_frame_start (bus.frame_start),
        .i_moving      (bus.moving),
        .o_anim_frame  (w_anim_frame)
    );

    // Position and direction only change at frame boundaries so the sprite never tears.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_lpos_x <= '0;
            r_lpos_y <= '0;
            r_ldir   <= DIR_DOWN;
        end else if (bus.frame_start) begin
            r_lpos_x <= bus.pos_x;
            r_lpos_y <= bus.pos_y;
            r_ldir   <= bus.dir;
        end
    end

    assign w_hit  = bus.active && in_span(bus.DrawX, r_lpos_x, SPR_W)
                               && in_span(bus.DrawY, r_lpos_y, SPR_H);
    assign w_xo   = XW'(bus.DrawX - r_lpos_x);
    assign w_yo   = YW'(bus.DrawY - r_lpos_y);
    assign w_addr = ADDR_W'({r_ldir, w_anim_frame, w_yo, w_xo});

    assign w_opaque = r_hit_s2 && (bus.rom_data != TRANSPARENT_IDX);

    // Every stage is reset so an interrupted line cannot leak a stale valid pixel.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_hit_s1    <= 1'b0;
            r_active_s1 <= 1'b0;
            r_rom_addr  <= '0;
            r_hit_s2    <= 1'b0;
            r_active_s2 <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pal_index <= '0;
            r_active_d  <= 1'b0;
        end else begin
            r_hit_s1    <= w_hit;
            r_active_s1 <= bus.active;
            r_rom_addr  <= w_hit ? w_addr : '0;
            r_hit_s2    <= r_hit_s1;
            r_active_s2 <= r_active_s1;
            r_pix_valid <= w_opaque;
            r_pal_index <= w_opaque ? bus.rom_data : 8'h00;
            r_active_d  <= r_active_s2;
        end
    end

    assign bus.rom_addr  = r_rom_addr;
    assign bus.pal_index = r_pal_index;
    assign bus.pix_valid = r_pix_valid;
    assign bus.active_d  = r_active_d;

endmodule

// File: tb/tb_piplup_sprite_fetch.sv
// Scoreboard bench for piplup_sprite_fetch with a synchronous sprite-ROM model.
module tb_piplup_sprite_fetch;
    import piplup_pkg::*;

    typedef struct {int due; logic [7:0] pal; logic vld; logic act;} exp_t;
    typedef struct {int cyc; logic [7:0] pal; logic vld; logic act;} obs_t;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   ncyc = 0;
    exp_t exp_q[$];
    obs_t obs_q[$];

    logic       rom_force = 1'b0;
    logic [7:0] rom_force_val = 8'h00;

    int m_lx, m_ly, m_dir, m_frame, m_tick;
    bit m_walk;

    always #5 Clk = ~Clk;

    piplup_sprite_fetch_if #(.ADDR_W(14)) bus ();

    piplup_sprite_fetch #(
        .SPR_W(32), .SPR_H(32), .FRAMES(4), .FRAME_TICKS(8),
        .TRANSPARENT_IDX(8'h00), .ADDR_W(14)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    function automatic logic [7:0] rom_fn(input logic [13:0] a);
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h5C;
    endfunction

    always @(posedge Clk) bus.rom_data <= rom_force ? rom_force_val : rom_fn(bus.rom_addr);

    always @(posedge Clk) begin
        ncyc++;
        #1;
        obs_q.push_back('{ncyc, bus.pal_index, bus.pix_valid, bus.active_d});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic reset_model();
        m_lx = 0; m_ly = 0; m_dir = 0; m_frame = 0; m_tick = 0; m_walk = 0;
        exp_q.delete();
    endtask

    // Drive one pixel cycle and push its expected outputs (due two edges after the sampling edge).
    task automatic px(input int x, input int y, input logic act, input logic fs);
        exp_t e;
        bit hit;
        int a;
        logic [7:0] d;
        @(negedge Clk);
        bus.DrawX = 10'(x); bus.DrawY = 10'(y); bus.active = act; bus.frame_start = fs;
        hit = act && x >= m_lx && x < m_lx + 32 && y >= m_ly && y < m_ly + 32;
        a = hit ? ((m_dir * 4 + m_frame) * 32 + (y - m_ly)) * 32 + (x - m_lx) : 0;
        d = rom_force ? rom_force_val : rom_fn(14'(a));
        e.due = ncyc + 3;
        e.vld = hit && (d != 8'h00);
        e.pal = e.vld ? d : 8'h00;
        e.act = act;
        exp_q.push_back(e);
        if (fs) begin
            m_lx = int'(bus.pos_x); m_ly = int'(bus.pos_y); m_dir = int'(bus.dir);
            if (m_walk) begin
                if (!bus.moving) begin m_walk = 0; m_frame = 0; m_tick = 0; end
                else if (m_tick == 7) begin m_tick = 0; m_frame = (m_frame + 1) % 4; end
                else m_tick++;
            end else if (bus.moving) m_walk = 1;
        end
    endtask

    task automatic pulse();
        px(0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        exp_t e; obs_t o;
        bus.DrawX = 0; bus.DrawY = 0; bus.active = 0; bus.frame_start = 0;
        bus.pos_x = 0; bus.pos_y = 0; bus.dir = DIR_DOWN; bus.moving = 0;
        reset_model();
        repeat (3) @(posedge Clk);
        #2;
        n_chk += 4;
        if (bus.rom_addr !== 14'd0)  begin n_fail++; $display("FAIL reset_rom_addr: got %0d want 0", bus.rom_addr); end
        if (bus.pal_index !== 8'h00) begin n_fail++; $display("FAIL reset_pal_index: got %h want 00", bus.pal_index); end
        if (bus.pix_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_pix_valid: got %b want 0", bus.pix_valid); end
        if (bus.active_d !== 1'b0)   begin n_fail++; $display("FAIL reset_active_d: got %b want 0", bus.active_d); end
        @(negedge Clk) Reset_n = 1'b1;
        px(0, 0, 1'b1, 1'b0);
        px(5, 3, 1'b1, 1'b0);
        px(40, 0, 1'b1, 1'b0);
        n_chk++;
        if (bus.rom_addr !== 14'd101) begin n_fail++; $display("FAIL reset_latch_addr: got %0d want 101", bus.rom_addr); end
        repeat (4) px(0, 0, 1'b0, 1'b0);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (o.cyc >= exp_q[0].due) begin
                e = exp_q.pop_front(); n_chk++;
                if (o.cyc != e.due || o.pal !== e.pal || o.vld !== e.vld || o.act !== e.act) begin
                    n_fail++;
                    $display("FAIL reset_sb cyc %0d: got pal=%h vld=%b act=%b, want pal=%h vld=%b act=%b (due %0d)",
                             o.cyc, o.pal, o.vld, o.act, e.pal, e.vld, e.act, e.due);
                end
            end
        end
    endtask

    task automatic test_hit_box();
        exp_t e; obs_t o;
        bus.pos_x = 100; bus.pos_y = 50; bus.dir = DIR_DOWN; bus.moving = 0;
        pulse();
        rom_force = 1'b1; rom_force_val = 8'h2A;
        px(100, 50, 1'b1, 1'b0);
        px(99, 50, 1'b1, 1'b0);
        n_chk++;
        if (bus.rom_addr !== 14'd0) begin n_fail++; $display("FAIL box_origin_addr: got %0d want 0", bus.rom_addr); end
        px(131, 81, 1'b1, 1'b0);
        px(132, 50, 1'b1, 1'b0);
        n_chk++;
        if (bus.rom_addr !== 14'd1023) begin n_fail++; $display("FAIL box_corner_addr: got %0d want 1023", bus.rom_addr); end
        px(100, 49, 1'b1, 1'b0);
        n_chk++;
        if (bus.rom_addr !== 14'd0) begin n_fail++; $display("FAIL box_miss_addr: got %0d want 0", bus.rom_addr); end
        px(100, 82, 1'b1, 1'b0);
        repeat (4) px(0, 0, 1'b0, 1'b0);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (o.cyc >= exp_q[0].due) begin
                e = exp_q.pop_front(); n_chk++;
                if (o.cyc != e.due || o.pal !== e.pal || o.vld !== e.vld || o.act !== e.act) begin
                    n_fail++;
                    $display("FAIL box_sb cyc %0d: got pal=%h vld=%b act=%b, want pal=%h vld=%b act=%b (due %0d)",
                             o.cyc, o.pal, o.vld, o.act, e.pal, e.vld, e.act, e.due);
                end
            end
        end
        rom_force = 1'b0;
    endtask

    task automatic test_transparent();
        exp_t e; obs_t o;
        rom_force = 1'b1; rom_force_val = 8'h00;
        for (int i = 0; i < 8; i++) px(104 + i, 60, 1'(i % 3 != 0), 1'b0);
        repeat (4) px(0, 0, 1'b0, 1'b0);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (o.cyc >= exp_q[0].due) begin
                e = exp_q.pop_front(); n_chk++;
                if (o.cyc != e.due || o.pal !== e.pal || o.vld !== e.vld || o.act !== e.act) begin
                    n_fail++;
                    $display("FAIL transparent_sb cyc %0d: got pal=%h vld=%b act=%b, want pal=%h vld=%b act=%b (due %0d)",
                             o.cyc, o.pal, o.vld, o.act, e.pal, e.vld, e.act, e.due);
                end
            end
        end
        rom_force = 1'b0;
    endtask

    task automatic test_anim();
        int want[6];
        int got[6];
        exp_t e; obs_t o;
        bus.pos_x = 100; bus.pos_y = 50; bus.dir = DIR_DOWN; bus.moving = 1;
        pulse();
        repeat (7) pulse();
        px(100, 50, 1'b1, 1'b0); px(0, 0, 1'b0, 1'b0); got[0] = int'(bus.rom_addr);
        pulse();
        px(100, 50, 1'b1, 1'b0); px(0, 0, 1'b0, 1'b0); got[1] = int'(bus.rom_addr);
        repeat (23) pulse();
        px(100, 50, 1'b1, 1'b0); px(0, 0, 1'b0, 1'b0); got[2] = int'(bus.rom_addr);
        pulse();
        px(100, 50, 1'b1, 1'b0); px(0, 0, 1'b0, 1'b0); got[3] = int'(bus.rom_addr);
        repeat (8) pulse();
        bus.moving = 0;
        pulse();
        px(100, 50, 1'b1, 1'b0); px(0, 0, 1'b0, 1'b0); got[4] = int'(bus.rom_addr);
        bus.moving = 1; bus.dir = DIR_RIGHT;
        repeat (17) pulse();
        px(100, 50, 1'b1, 1'b0); px(0, 0, 1'b0, 1'b0); got[5] = int'(bus.rom_addr);
        want = '{0, 1024, 3072, 0, 0, 14336};
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (got[i] != want[i]) begin
                n_fail++;
                $display("FAIL anim_addr[%0d]: got %0d want %0d", i, got[i], want[i]);
            end
        end
        bus.dir = DIR_LEFT;
        pulse();
        px(100, 50, 1'b1, 1'b0); px(0, 0, 1'b0, 1'b0);
        n_chk++;
        if (bus.rom_addr !== 14'd10240) begin n_fail++; $display("FAIL anim_dir_keeps_frame: got %0d want 10240", bus.rom_addr); end
        bus.moving = 0; bus.dir = DIR_DOWN;
        pulse();
        repeat (4) px(0, 0, 1'b0, 1'b0);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (o.cyc >= exp_q[0].due) begin
                e = exp_q.pop_front(); n_chk++;
                if (o.cyc != e.due || o.pal !== e.pal || o.vld !== e.vld || o.act !== e.act) begin
                    n_fail++;
                    $display("FAIL anim_sb cyc %0d: got pal=%h vld=%b act=%b, want pal=%h vld=%b act=%b (due %0d)",
                             o.cyc, o.pal, o.vld, o.act, e.pal, e.vld, e.act, e.due);
                end
            end
        end
    endtask

    task automatic test_clip_latch();
        exp_t e; obs_t o;
        bus.pos_x = 620; bus.pos_y = 470; bus.dir = DIR_DOWN; bus.moving = 0;
        pulse();
        px(639, 479, 1'b1, 1'b0);
        px(619, 479, 1'b1, 1'b0);
        n_chk++;
        if (bus.rom_addr !== 14'd307) begin n_fail++; $display("FAIL clip_corner_addr: got %0d want 307", bus.rom_addr); end
        bus.pos_x = 0;
        px(639, 479, 1'b1, 1'b0);
        px(5, 479, 1'b1, 1'b0);
        n_chk++;
        if (bus.rom_addr !== 14'd307) begin n_fail++; $display("FAIL latch_hold_addr: got %0d want 307", bus.rom_addr); end
        pulse();
        px(5, 479, 1'b1, 1'b0);
        px(639, 479, 1'b1, 1'b0);
        n_chk++;
        if (bus.rom_addr !== 14'd293) begin n_fail++; $display("FAIL latch_update_addr: got %0d want 293", bus.rom_addr); end
        repeat (4) px(0, 0, 1'b0, 1'b0);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (o.cyc >= exp_q[0].due) begin
                e = exp_q.pop_front(); n_chk++;
                if (o.cyc != e.due || o.pal !== e.pal || o.vld !== e.vld || o.act !== e.act) begin
                    n_fail++;
                    $display("FAIL clip_sb cyc %0d: got pal=%h vld=%b act=%b, want pal=%h vld=%b act=%b (due %0d)",
                             o.cyc, o.pal, o.vld, o.act, e.pal, e.vld, e.act, e.due);
                end
            end
        end
    endtask

    task automatic test_reset_midline();
        bit seen;
        exp_t e; obs_t o;
        rom_force = 1'b1; rom_force_val = 8'h77;
        bus.pos_x = 100; bus.pos_y = 50; bus.dir = DIR_DOWN; bus.moving = 0;
        pulse();
        px(100, 50, 1'b1, 1'b0);
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge Clk); #1;
            seen = (bus.pix_valid === 1'b1);
        end
        n_chk++;
        if (!seen) begin n_fail++; $display("FAIL midline_valid_seen: got pix_valid=%b want 1 within 8 clocks", bus.pix_valid); end
        #1 Reset_n = 1'b0;
        #1;
        n_chk += 4;
        if (bus.rom_addr !== 14'd0)  begin n_fail++; $display("FAIL midline_rom_addr: got %0d want 0", bus.rom_addr); end
        if (bus.pal_index !== 8'h00) begin n_fail++; $display("FAIL midline_pal_index: got %h want 00", bus.pal_index); end
        if (bus.pix_valid !== 1'b0)  begin n_fail++; $display("FAIL midline_pix_valid: got %b want 0", bus.pix_valid); end
        if (bus.active_d !== 1'b0)   begin n_fail++; $display("FAIL midline_active_d: got %b want 0", bus.active_d); end
        reset_model();
        @(negedge Clk) Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            n_chk++;
            if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_pix_valid[%0d]: got %b want 0", i, bus.pix_valid); end
        end
        px(100, 50, 1'b1, 1'b0);
        px(10, 10, 1'b1, 1'b0);
        repeat (4) px(0, 0, 1'b0, 1'b0);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (o.cyc >= exp_q[0].due) begin
                e = exp_q.pop_front(); n_chk++;
                if (o.cyc != e.due || o.pal !== e.pal || o.vld !== e.vld || o.act !== e.act) begin
                    n_fail++;
                    $display("FAIL post_reset_sb cyc %0d: got pal=%h vld=%b act=%b, want pal=%h vld=%b act=%b (due %0d)",
                             o.cyc, o.pal, o.vld, o.act, e.pal, e.vld, e.act, e.due);
                end
            end
        end
        rom_force = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hit_box();
        test_transparent();
        test_anim();
        test_clip_latch();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
